// File: rtl/dpi_trace_pkg.sv
// dpi_trace_pkg: shared trace field codes, replay FSM states and lane width helpers
package dpi_trace_pkg;
  localparam int TYPE_RDAT  = 0;
  localparam int TYPE_RDATK = 1;
  localparam int TYPE_RDATV = 2;
  localparam int TYPE_TDAT  = 3;
  localparam int TYPE_TDATK = 4;
  localparam int TYPE_TDATV = 5;
  localparam int NUM_TYPES  = 6;
  localparam logic [NUM_TYPES-1:0] SEEN_ALL = '1;
  typedef enum logic [1:0] {COLLECT, PRESENT, DONE} state_t;
  function automatic int bytes_per_lane(input int width);
    return width >> 16;
  endfunction
  function automatic int data_width(input int lans, input int width);
    return lans * bytes_per_lane(width) * 8;
  endfunction
  function automatic int k_width(input int lans, input int width);
    return lans * bytes_per_lane(width);
  endfunction
endpackage

// File: rtl/dpi_replay_shadow.sv
// dpi_replay_shadow: per-frame shadow fields and seen mask, with a write-through view of the pending record
module dpi_replay_shadow import dpi_trace_pkg::*; #(
  parameter int DW = 128,
  parameter int KW = 16,
  parameter int VW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_we,
  input  logic [2:0]           i_type,
  input  logic [127:0]         i_data,
  input  logic                 i_clr,
  output logic [DW-1:0]        o_rdat,
  output logic [KW-1:0]        o_rdatk,
  output logic [VW-1:0]        o_rdatv,
  output logic [DW-1:0]        o_tdat,
  output logic [KW-1:0]        o_tdatk,
  output logic [VW-1:0]        o_tdatv,
  output logic [NUM_TYPES-1:0] o_seen
);
  logic [DW-1:0]        r_rdat, r_tdat;
  logic [KW-1:0]        r_rdatk, r_tdatk;
  logic [VW-1:0]        r_rdatv, r_tdatv;
  logic [NUM_TYPES-1:0] r_seen, w_hit;
  assign w_hit   = i_we ? NUM_TYPES'(1) << i_type : '0;
  assign o_rdat  = w_hit[TYPE_RDAT]  ? DW'(i_data) : r_rdat;
  assign o_rdatk = w_hit[TYPE_RDATK] ? KW'(i_data) : r_rdatk;
  assign o_rdatv = w_hit[TYPE_RDATV] ? VW'(i_data) : r_rdatv;
  assign o_tdat  = w_hit[TYPE_TDAT]  ? DW'(i_data) : r_tdat;
  assign o_tdatk = w_hit[TYPE_TDATK] ? KW'(i_data) : r_tdatk;
  assign o_tdatv = w_hit[TYPE_TDATV] ? VW'(i_data) : r_tdatv;
  assign o_seen  = r_seen | w_hit;
  // shadow registers follow the view; a frame handoff only clears the seen mask
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdat  <= '0;
      r_rdatk <= '0;
      r_rdatv <= '0;
      r_tdat  <= '0;
      r_tdatk <= '0;
      r_tdatv <= '0;
      r_seen  <= '0;
    end else begin
      r_rdat  <= o_rdat;
      r_rdatk <= o_rdatk;
      r_rdatv <= o_rdatv;
      r_tdat  <= o_tdat;
      r_tdatk <= o_tdatk;
      r_tdatv <= o_tdatv;
      r_seen  <= i_clr ? '0 : o_seen;
    end
  end
endmodule

// File: rtl/dpi_replay.sv
// dpi_replay: rebuilds one lane frame per trace cycle from time-ordered records; DPI_REPLAY_STATS_EN enables frame/partial counters
module dpi_replay import dpi_trace_pkg::*; #(
  parameter int LANS  = 4,
  parameter int WIDTH = 'h044444,
  localparam int DW = data_width(LANS, WIDTH),
  localparam int KW = k_width(LANS, WIDTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rec_valid,
  output logic            rec_ready,
  input  logic [63:0]     rec_time,
  input  logic [5:0]      rec_type,
  input  logic [127:0]    rec_data,
  input  logic            rec_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [63:0]     out_time,
  output logic [DW-1:0]   rdat,
  output logic [KW-1:0]   rdatk,
  output logic [LANS-1:0] rdatv,
  output logic [DW-1:0]   tdat,
  output logic [KW-1:0]   tdatk,
  output logic [LANS-1:0] tdatv,
  output logic            frame_partial,
  output logic            err_order,
  output logic            err_type,
  output logic            done,
  output logic [31:0]     frame_cnt,
  output logic [31:0]     partial_cnt
);
  state_t               r_state, w_state_nxt;
  logic [63:0]          r_cur_time, r_out_time;
  logic                 r_last, r_partial, r_err_order, r_err_type;
  logic [DW-1:0]        r_rdat, r_tdat, w_rdat, w_tdat;
  logic [KW-1:0]        r_rdatk, r_tdatk, w_rdatk, w_tdatk;
  logic [LANS-1:0]      r_rdatv, r_tdatv, w_rdatv, w_tdatv;
  logic [NUM_TYPES-1:0] w_seen;
  logic                 w_bad, w_late, w_future, w_acc, w_we, w_clr, w_close;
  assign w_bad     = rec_type >= 6'(NUM_TYPES);
  assign w_late    = rec_time < r_cur_time;
  assign w_future  = rec_time > r_cur_time;
  assign rec_ready = r_state == COLLECT && !(rec_valid && w_future);
  assign out_valid = r_state == PRESENT;
  assign done      = r_state == DONE;
  assign w_acc     = rec_valid && rec_ready;
  assign w_we      = w_acc && !w_late && !w_bad;
  assign w_clr     = out_valid && out_ready;
  assign w_close   = r_state == COLLECT && ((rec_valid && w_future) || (w_acc && rec_last) || w_seen == SEEN_ALL);
  assign out_time      = r_out_time;
  assign rdat          = r_rdat;
  assign rdatk         = r_rdatk;
  assign rdatv         = r_rdatv;
  assign tdat          = r_tdat;
  assign tdatk         = r_tdatk;
  assign tdatv         = r_tdatv;
  assign frame_partial = r_partial;
  assign err_order     = r_err_order;
  assign err_type      = r_err_type;
  dpi_replay_shadow #(.DW(DW), .KW(KW), .VW(LANS)) u_shadow (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_type  (rec_type[2:0]),
    .i_data  (rec_data),
    .i_clr   (w_clr),
    .o_rdat  (w_rdat),
    .o_rdatk (w_rdatk),
    .o_rdatv (w_rdatv),
    .o_tdat  (w_tdat),
    .o_tdatk (w_tdatk),
    .o_tdatv (w_tdatv),
    .o_seen  (w_seen)
  );
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= COLLECT;
    else r_state <= w_state_nxt;
  end
  // close a frame on a future head, rec_last or a full mask; leave PRESENT on handoff
  always_comb begin
    w_state_nxt = w_close ? PRESENT : w_clr ? (r_last ? DONE : COLLECT) : r_state;
  end
  // frame assembly: seen fields refresh from the shadow view, unseen fields hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_time  <= '0;
      r_out_time  <= '0;
      r_last      <= 1'b0;
      r_partial   <= 1'b0;
      r_err_order <= 1'b0;
      r_err_type  <= 1'b0;
      r_rdat      <= '0;
      r_rdatk     <= '0;
      r_rdatv     <= '0;
      r_tdat      <= '0;
      r_tdatk     <= '0;
      r_tdatv     <= '0;
    end else begin
      r_err_order <= r_err_order | (w_acc && w_late);
      r_err_type  <= r_err_type | (w_acc && w_bad);
      if (w_close) begin
        r_rdat     <= w_seen[TYPE_RDAT]  ? w_rdat  : r_rdat;
        r_rdatk    <= w_seen[TYPE_RDATK] ? w_rdatk : r_rdatk;
        r_rdatv    <= w_seen[TYPE_RDATV] ? w_rdatv : r_rdatv;
        r_tdat     <= w_seen[TYPE_TDAT]  ? w_tdat  : r_tdat;
        r_tdatk    <= w_seen[TYPE_TDATK] ? w_tdatk : r_tdatk;
        r_tdatv    <= w_seen[TYPE_TDATV] ? w_tdatv : r_tdatv;
        r_out_time <= r_cur_time;
        r_partial  <= w_seen != SEEN_ALL;
        r_last     <= w_acc && rec_last;
      end
      if (w_clr) r_cur_time <= r_cur_time + 64'd1;
    end
  end
`ifdef DPI_REPLAY_STATS_EN
  logic [31:0] r_frame_cnt, r_partial_cnt;
  // saturating handshake statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt   <= '0;
      r_partial_cnt <= '0;
    end else if (w_clr) begin
      r_frame_cnt   <= r_frame_cnt + {31'd0, r_frame_cnt != '1};
      r_partial_cnt <= r_partial_cnt + {31'd0, r_partial && r_partial_cnt != '1};
    end
  end
  assign frame_cnt   = r_frame_cnt;
  assign partial_cnt = r_partial_cnt;
`else
  assign frame_cnt   = '0;
  assign partial_cnt = '0;
`endif
endmodule

// File: tb/tb_dpi_replay.sv
// tb_dpi_replay: directed table, corner sequences and randomized traces against a record-level replay model
module tb_dpi_replay;
  localparam int LANS = 4;
  localparam int DW = 128;
  localparam int KW = 16;
  logic clk = 1'b0;
  logic rst, rec_valid, rec_ready, rec_last, out_valid, out_ready;
  logic frame_partial, err_order, err_type, done;
  logic [63:0] rec_time, out_time;
  logic [5:0] rec_type;
  logic [127:0] rec_data;
  logic [DW-1:0] rdat, tdat;
  logic [KW-1:0] rdatk, tdatk;
  logic [LANS-1:0] rdatv, tdatv;
  logic [31:0] frame_cnt, partial_cnt;
  always #5 clk = ~clk;
  dpi_replay #(.LANS(LANS), .WIDTH('h044444)) dut (
    .clk(clk), .rst(rst), .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_time(rec_time),
    .rec_type(rec_type), .rec_data(rec_data), .rec_last(rec_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_time(out_time), .rdat(rdat), .rdatk(rdatk), .rdatv(rdatv),
    .tdat(tdat), .tdatk(tdatk), .tdatv(tdatv), .frame_partial(frame_partial),
    .err_order(err_order), .err_type(err_type), .done(done), .frame_cnt(frame_cnt),
    .partial_cnt(partial_cnt)
  );
  typedef struct {logic [63:0] t; logic [5:0] ty; logic [127:0] d; bit last;} rec_t;
  typedef struct {logic [63:0] t; bit p; logic [5:0][127:0] fld;} frm_t;
  typedef struct {logic [63:0] t; bit p; logic [5:0][7:0] src;} dexp_t;
  rec_t recs[$];
  frm_t exp_q[$], got_q[$];
  dexp_t dt[7];
  int checks = 0, errors = 0;
  bit exp_eo, exp_et;
  logic [63:0] m_cur;
  logic [5:0] m_seen;
  logic [5:0][127:0] m_sh, m_held;
  function automatic logic [127:0] mask(input int ty, input logic [127:0] d);
    if (ty == 0 || ty == 3) return d;
    if (ty == 1 || ty == 4) return {112'd0, d[15:0]};
    if (ty == 2 || ty == 5) return {124'd0, d[3:0]};
    return '0;
  endfunction
  function automatic logic [127:0] pat(input logic [63:0] t, input int ty);
    logic [31:0] w;
    w = t[31:0] * 32'h9E3779B1 + 32'(ty) * 32'h7F4A7C15 + 32'h13579BDF;
    return {w, ~w, w ^ 32'hDEADBEEF, w + 32'h5};
  endfunction
  task automatic add(input logic [63:0] t, input int ty, input logic [127:0] d, input bit last);
    rec_t r;
    r.t = t; r.ty = 6'(ty); r.d = d; r.last = last;
    recs.push_back(r);
  endtask
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask
  function automatic frm_t cap();
    frm_t f;
    f.t = out_time; f.p = frame_partial;
    f.fld[0] = 128'(rdat); f.fld[1] = 128'(rdatk); f.fld[2] = 128'(rdatv);
    f.fld[3] = 128'(tdat); f.fld[4] = 128'(tdatk); f.fld[5] = 128'(tdatv);
    return f;
  endfunction
  task automatic emit();
    frm_t e;
    for (int k = 0; k < 6; k++) if (m_seen[k]) m_held[k] = m_sh[k];
    e.t = m_cur; e.p = (m_seen != 6'h3F); e.fld = m_held;
    exp_q.push_back(e);
    m_cur++;
    m_seen = '0;
  endtask
  task automatic build_expected();
    int i = 0;
    int k;
    exp_q.delete(); m_cur = '0; m_seen = '0; m_sh = '0; m_held = '0; exp_eo = 0; exp_et = 0;
    while (i < recs.size()) begin
      if (recs[i].t > m_cur) emit();
      else begin
        k = int'(recs[i].ty);
        if (recs[i].t < m_cur) exp_eo = 1;
        if (k > 5) exp_et = 1;
        if (recs[i].t == m_cur && k <= 5) begin
          m_sh[k] = mask(k, recs[i].d);
          m_seen[k] = 1'b1;
        end
        if (recs[i].last) begin
          emit();
          i = recs.size();
        end else begin
          if (m_seen == 6'h3F) emit();
          i++;
        end
      end
    end
  endtask
  task automatic do_reset();
    rst = 1'b1; rec_valid = 1'b0; out_ready = 1'b0;
    rec_time = '0; rec_type = '0; rec_data = '0; rec_last = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic drive(input rec_t r);
    rec_valid = 1'b1; rec_time = r.t; rec_type = r.ty; rec_data = r.d; rec_last = r.last;
  endtask
  task automatic run_trace(input string nm, input int vpct, input int rpct);
    int idx = 0;
    got_q.delete();
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clk);
      if (idx < recs.size() && $urandom_range(99) < vpct) drive(recs[idx]);
      else rec_valid = 1'b0;
      out_ready = $urandom_range(99) < rpct;
      #1;
      if (rec_valid && rec_ready) idx++;
      if (out_valid && out_ready) got_q.push_back(cap());
    end
    rec_valid = 1'b0; out_ready = 1'b0;
    chk({nm, " done_reached"}, 128'(done), 128'd1);
  endtask
  task automatic chk_frames(input string nm);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s frame_count got=%0d exp=%0d", nm, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].t !== exp_q[i].t || got_q[i].p !== exp_q[i].p || got_q[i].fld !== exp_q[i].fld) begin
        errors++;
        $display("FAIL %s frame %0d time got=%0d exp=%0d partial got=%0d exp=%0d",
                 nm, i, got_q[i].t, exp_q[i].t, got_q[i].p, exp_q[i].p);
        for (int k = 0; k < 6; k++)
          if (got_q[i].fld[k] !== exp_q[i].fld[k])
            $display("  %s frame %0d field %0d got=%h exp=%h", nm, i, k, got_q[i].fld[k], exp_q[i].fld[k]);
      end
    end
  endtask
  task automatic chk_stats(input string nm);
    int np = 0;
    foreach (exp_q[i]) np += int'(exp_q[i].p);
`ifdef DPI_REPLAY_STATS_EN
    chk({nm, " frame_cnt"}, 128'(frame_cnt), 128'(exp_q.size()));
    chk({nm, " partial_cnt"}, 128'(partial_cnt), 128'(np));
`else
    chk({nm, " frame_cnt"}, 128'(frame_cnt), 128'd0);
    chk({nm, " partial_cnt"}, 128'(partial_cnt), 128'(np * 0));
`endif
  endtask
  initial begin
    rec_t r;
    frm_t e;
    int t;
    dt = '{'{64'd0, 1'b0, 48'h000000000000}, '{64'd1, 1'b0, 48'h010101010101},
           '{64'd2, 1'b1, 48'h010101020102}, '{64'd3, 1'b1, 48'h010101020102},
           '{64'd4, 1'b1, 48'h010101020102}, '{64'd5, 1'b0, 48'h050505050505},
           '{64'd6, 1'b0, 48'h060606060606}};
    do_reset();
    #1;
    chk("rst out_valid", 128'(out_valid), 128'd0);
    chk("rst rec_ready", 128'(rec_ready), 128'd1);
    chk("rst done", 128'(done), 128'd0);
    chk("rst errs", 128'({err_order, err_type, frame_partial}), 128'd0);
    chk("rst fields", 128'(rdat | tdat | 128'(rdatk) | 128'(tdatk) | 128'(rdatv) | 128'(tdatv)), 128'd0);
    chk("rst out_time", 128'(out_time), 128'd0);
    chk("rst counters", 128'({frame_cnt, partial_cnt}), 128'd0);
    // directed trace: full frames, partial + gap frames, bad type, late stamp, duplicate, last
    recs.delete();
    for (int k = 0; k < 6; k++) add(0, k, pat(0, k), 0);
    for (int k = 0; k < 6; k++) add(1, k, pat(1, k), 0);
    add(2, 0, pat(2, 0), 0); add(2, 2, pat(2, 2), 0);
    add(5, 7, pat(5, 7), 0); add(5, 1, pat(5, 1), 0); add(0, 3, ~pat(0, 3), 0);
    add(5, 4, ~pat(5, 4), 0); add(5, 0, pat(5, 0), 0); add(5, 2, pat(5, 2), 0);
    add(5, 3, pat(5, 3), 0); add(5, 4, pat(5, 4), 0); add(5, 5, pat(5, 5), 0);
    for (int k = 0; k < 6; k++) add(6, k, pat(6, k), k == 5);
    exp_q.delete();
    foreach (dt[i]) begin
      e.t = dt[i].t; e.p = dt[i].p;
      for (int k = 0; k < 6; k++) e.fld[k] = mask(k, pat(64'(dt[i].src[k]), k));
      exp_q.push_back(e);
    end
    run_trace("dir", 100, 100);
    chk_frames("dir");
    chk("dir err_type", 128'(err_type), 128'd1);
    chk("dir err_order", 128'(err_order), 128'd1);
    chk_stats("dir");
    @(negedge clk); #1;
    chk("dir done_held", 128'({done, rec_ready, out_valid}), 128'b100);
    // latency and stall: out_valid one cycle after the sixth record, stable while out_ready low
    do_reset();
    for (int k = 0; k < 6; k++) begin
      r.t = 0; r.ty = 6'(k); r.d = pat(0, k); r.last = 0;
      @(negedge clk); drive(r); #1;
      chk($sformatf("lat ready%0d", k), 128'({rec_ready, out_valid}), 128'b10);
    end
    r.t = 1; r.ty = 0; r.d = pat(1, 0);
    @(negedge clk); drive(r); #1;
    chk("lat out_valid", 128'({out_valid, rec_ready, frame_partial}), 128'b100);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      chk($sformatf("stall%0d", c), 128'({out_valid, rec_ready}), 128'b10);
      chk($sformatf("stall%0d rdat", c), 128'(rdat), pat(0, 0));
    end
    @(negedge clk); rec_valid = 1'b0;
    recs.delete();
    for (int k = 0; k < 6; k++) add(1, k, pat(1, k), k == 5);
    exp_q.delete();
    e.t = 0; e.p = 0;
    for (int k = 0; k < 6; k++) e.fld[k] = mask(k, pat(0, k));
    exp_q.push_back(e);
    e.t = 1;
    for (int k = 0; k < 6; k++) e.fld[k] = mask(k, pat(1, k));
    exp_q.push_back(e);
    out_ready = 1'b1; #1;
    got_q.delete();
    if (out_valid) got_q.push_back(cap());
    begin
      frm_t keep;
      keep = got_q.size() > 0 ? got_q[0] : e;
      run_trace("stall", 100, 100);
      got_q.push_front(keep);
    end
    chk_frames("stall");
    // reset mid-frame discards the shadow: a later frame must not carry pre-reset data
    do_reset();
    for (int k = 0; k < 3; k++) begin
      r.t = 0; r.ty = 6'(k); r.d = pat(9, k); r.last = 0;
      @(negedge clk); drive(r);
    end
    @(negedge clk); rst = 1'b1; rec_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    recs.delete();
    for (int k = 3; k < 6; k++) add(0, k, pat(0, k), k == 5);
    build_expected();
    run_trace("midrst", 100, 100);
    chk_frames("midrst");
    chk("midrst partial", 128'(exp_q.size() > 0 ? exp_q[0].p : 1'b0), 128'd1);
    // randomized traces with gaps, duplicates, bad types and late stamps
    for (int it = 0; it < 5; it++) begin
      do_reset();
      recs.delete();
      t = 0;
      for (int s = 0; s < 25; s++) begin
        if ($urandom_range(4) == 0) t += int'($urandom_range(3, 1));
        for (int n = int'($urandom_range(7)); n > 0; n--) begin
          logic [63:0] rt;
          int ty;
          rt = 64'(t);
          ty = int'($urandom_range(5));
          if ($urandom_range(15) == 0) ty = int'($urandom_range(63, 6));
          if (t > 0 && $urandom_range(15) == 0) rt = 64'($urandom_range(t - 1));
          add(rt, ty, {$urandom, $urandom, $urandom, $urandom}, 0);
        end
        t++;
      end
      add(64'(t), int'($urandom_range(5)), {$urandom, $urandom, $urandom, $urandom}, 1);
      build_expected();
      run_trace($sformatf("rnd%0d", it), 70, 60);
      chk_frames($sformatf("rnd%0d", it));
      chk($sformatf("rnd%0d errs", it), 128'({err_order, err_type}), 128'({exp_eo, exp_et}));
      chk_stats($sformatf("rnd%0d", it));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
